router_1xn_pkt: RTL and testbench



---
 rtl/router_1xn_pkt_if.sv | 46 ++++
 rtl/router_1xn_pkt.sv | 202 ++++++++++++++++++++
 tb/tb_router_1xn_pkt.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_1xn_pkt_if.sv
`default_nettype none
// ============================================================================
//  Module   : router_1xn_pkt_if
//  Purpose  : Bundles the packet-stream input and the per-port output FIFO
//             signals of router_1xn_pkt.
//  Modports : master - packet source / downstream consumers (drives
//                      packet_in, packet_valid_i, read_enb)
//             slave  - the router itself
//  Signals  : packet_in        input byte
//             packet_valid_i   packet_in valid this cycle
//             stop_packet_send byte cannot be accepted this cycle
//             read_enb         per-port pop request
//             packet_valid_o   per-port FIFO non-empty
//             packet_out       per-port FIFO head, port i at [i*DW +: DW]
//             parity_err       one-cycle pulse on parity mismatch
//             pkt_dropped      one-cycle pulse when a dropped packet completes
//             port_flushed     per-port one-cycle timeout-flush pulse
//  Revision : 1.0 - initial release
// ============================================================================
interface router_1xn_pkt_if #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]           packet_in;
  logic                            packet_valid_i;
  logic                            stop_packet_send;
  logic [NUM_PORTS-1:0]            read_enb;
  logic [NUM_PORTS-1:0]            packet_valid_o;
  logic [NUM_PORTS*DATA_WIDTH-1:0] packet_out;
  logic                            parity_err;
  logic                            pkt_dropped;
  logic [NUM_PORTS-1:0]            port_flushed;

  modport master (
    output packet_in, packet_valid_i, read_enb,
    input  stop_packet_send, packet_valid_o, packet_out,
           parity_err, pkt_dropped, port_flushed
  );

  modport slave (
    input  packet_in, packet_valid_i, read_enb,
    output stop_packet_send, packet_valid_o, packet_out,
           parity_err, pkt_dropped, port_flushed
  );
endinterface
`default_nettype wire

// File: rtl/router_1xn_pkt.sv
`default_nettype none
// ============================================================================
//  Module   : router_1xn_pkt
//  Purpose  : 1xN packet router. Parses header/payload/parity packets from a
//             single byte stream and steers each packet into one of NUM_PORTS
//             first-word-fall-through FIFOs. Checks parity, drops packets
//             with an out-of-range destination, and flushes any port left
//             unread for TIMEOUT cycles.
//  Ports    : clk  - clock
//             rst  - asynchronous active-high reset
//             bus  - router_1xn_pkt_if.slave (stream in, FIFO outputs,
//                    status pulses)
//  Revision : 1.0 - initial release
// ============================================================================
module router_1xn_pkt #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  router_1xn_pkt_if.slave      bus
);

  localparam int c_ADDR_W = $clog2(NUM_PORTS);
  localparam int c_LEN_W  = DATA_WIDTH - c_ADDR_W;
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [c_ADDR_W:0]    c_NPORTS  = (c_ADDR_W + 1)'(NUM_PORTS);
  localparam logic [c_LEN_W-1:0]   c_LEN_ONE = c_LEN_W'(1);
  localparam logic [c_PTR_W:0]     c_PTR_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_TMR_W-1:0]   c_TMR_ONE = c_TMR_W'(1);
  localparam logic [c_TMR_W-1:0]   c_TMR_MAX = c_TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PARITY  = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_ADDR_W-1:0]   r_dest;
  logic [c_LEN_W-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_xor;
  logic                  r_parity_err, r_pkt_dropped;

  logic [c_ADDR_W-1:0]   w_hdr_dest;
  logic [c_LEN_W-1:0]    w_hdr_len;
  logic                  w_hdr_ok;
  logic [NUM_PORTS-1:0]  w_full, w_empty;
  logic                  w_stop, w_accept;
  logic                  w_wr_en;
  logic [c_ADDR_W-1:0]   w_wr_port;
  logic                  w_parity_fail, w_drop_done;

  assign w_hdr_dest = bus.packet_in[c_ADDR_W-1:0];
  assign w_hdr_len  = bus.packet_in[DATA_WIDTH-1:c_ADDR_W];
  assign w_hdr_ok   = ({1'b0, w_hdr_dest} < c_NPORTS);

  // Full is taken from the pre-edge pointers, so a pop in the same cycle
  // does not release backpressure until the following cycle.
  always_comb begin
    w_stop = 1'b0;
    case (r_state)
      S_IDLE:              w_stop = bus.packet_valid_i && w_hdr_ok && w_full[w_hdr_dest];
      S_PAYLOAD, S_PARITY: w_stop = w_full[r_dest];
      default:             w_stop = 1'b0;
    endcase
  end

  assign w_accept             = bus.packet_valid_i && !w_stop;
  assign bus.stop_packet_send = w_stop;

  // Next-state and write-steering decode
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en       = 1'b0;
    w_wr_port     = r_dest;
    w_parity_fail = 1'b0;
    w_drop_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hdr_ok) begin
            w_wr_en     = 1'b1;
            w_wr_port   = w_hdr_dest;
            w_state_nxt = (w_hdr_len == '0) ? S_PARITY : S_PAYLOAD;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (r_cnt == c_LEN_ONE) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_accept) begin
          w_wr_en       = 1'b1;
          w_parity_fail = (bus.packet_in != r_xor);
          w_state_nxt   = S_IDLE;
        end
      end
      S_DROP: begin
        // r_cnt holds the bytes still to skip after the current one
        if (w_accept && (r_cnt == '0)) begin
          w_drop_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dest        <= '0;
      r_cnt         <= '0;
      r_xor         <= '0;
      r_parity_err  <= 1'b0;
      r_pkt_dropped <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_parity_err  <= w_parity_fail;
      r_pkt_dropped <= w_drop_done;
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= w_hdr_len;
            r_xor <= bus.packet_in;
            if (w_hdr_ok) r_dest <= w_hdr_dest;
          end
          S_PAYLOAD: begin
            r_cnt <= r_cnt - c_LEN_ONE;
            r_xor <= r_xor ^ bus.packet_in;
          end
          S_DROP:  r_cnt <= r_cnt - c_LEN_ONE;
          default: ;
        endcase
      end
    end
  end

  assign bus.parity_err  = r_parity_err;
  assign bus.pkt_dropped = r_pkt_dropped;

  // Per-port FIFO with timeout flush
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      localparam logic [c_ADDR_W-1:0] c_IDX = c_ADDR_W'(gi);

      logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [c_PTR_W:0]      r_wr_ptr, r_rd_ptr;
      logic [c_TMR_W-1:0]    r_tmr;
      logic                  w_we, w_pop, w_flush;

      assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
      assign w_full[gi]  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                           (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

      // A flush edge discards any byte written to this port on that edge
      assign w_flush = (TIMEOUT != 0) && (r_tmr == c_TMR_MAX);
      assign w_we    = w_wr_en && (w_wr_port == c_IDX) && !w_flush;
      assign w_pop   = bus.read_enb[gi] && !w_empty[gi];

      always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= bus.packet_in;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_tmr    <= '0;
        end else if (w_flush) begin
          r_rd_ptr <= r_wr_ptr;
          r_tmr    <= '0;
        end else begin
          if (w_we)  r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
          if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
          // Non-empty and not popped means unread this cycle
          if (w_empty[gi] || w_pop) r_tmr <= '0;
          else if (TIMEOUT != 0)    r_tmr <= r_tmr + c_TMR_ONE;
        end
      end

      assign bus.packet_valid_o[gi] = !w_empty[gi];
      assign bus.packet_out[gi*DATA_WIDTH +: DATA_WIDTH] =
        w_empty[gi] ? '0 : r_mem[r_rd_ptr[c_PTR_W-1:0]];
      assign bus.port_flushed[gi] = w_flush;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_router_1xn_pkt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_1xn_pkt
//  Purpose  : Self-checking bench for router_1xn_pkt. A queue-based reference
//             model tracks every output each cycle; directed sequences and a
//             table of packets cover routing, parity, drop, backpressure,
//             timeout and reset, followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_1xn_pkt;
  localparam int NP = 3;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int TO = 30;
  localparam int AW = $clog2(NP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_1xn_pkt_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

  router_1xn_pkt #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queues per port ----------------
  bit [7:0] mq [NP][$];
  int       mtmr [NP];
  int       m_left;   // bytes still owed by the current packet, 0 = between packets
  bit       m_drop;
  int       m_dest;
  bit [7:0] m_xor;
  bit       m_err, m_dpulse;

  function automatic bit exp_stop();
    int d;
    if (m_left == 0) begin
      d = int'(bus.packet_in) % (1 << AW);
      return bus.packet_valid_i && (d < NP) && (mq[d].size() == DEPTH);
    end
    if (!m_drop) return mq[m_dest].size() == DEPTH;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit acc;
    int wport, d, len;
    bit [7:0] b;
    int sz [NP];
    bit fl [NP];
    bit pp [NP];
    b = bus.packet_in;
    acc = bus.packet_valid_i && !exp_stop();
    wport = -1;
    m_err = 0;
    m_dpulse = 0;
    for (int i = 0; i < NP; i++) begin
      sz[i] = mq[i].size();
      fl[i] = (TO != 0) && (mtmr[i] == TO);
      pp[i] = bus.read_enb[i] && (sz[i] > 0);
    end
    if (acc) begin
      if (m_left == 0) begin
        d = int'(b) % (1 << AW);
        len = int'(b) / (1 << AW);
        m_left = len + 1;
        if (d < NP) begin
          m_drop = 0; m_dest = d; m_xor = b; wport = d;
        end else begin
          m_drop = 1;
        end
      end else if (m_drop) begin
        m_left--;
        if (m_left == 0) m_dpulse = 1;
      end else begin
        wport = m_dest;
        if (m_left == 1) m_err = (b != m_xor);
        else m_xor ^= b;
        m_left--;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (fl[i]) begin
        mq[i].delete();
        mtmr[i] = 0;
      end else begin
        if (pp[i]) void'(mq[i].pop_front());
        if (wport == i) mq[i].push_back(b);
        if (sz[i] == 0 || pp[i]) mtmr[i] = 0;
        else mtmr[i]++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        mq[i].delete();
        mtmr[i] = 0;
      end
      m_left = 0; m_drop = 0; m_dest = 0; m_xor = 0; m_err = 0; m_dpulse = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- cycle monitor against the model ----------------
  logic [NP-1:0]    e_pv, e_fl;
  logic [NP*DW-1:0] e_out;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        e_pv[i] = mq[i].size() > 0;
        e_out[i*DW +: DW] = e_pv[i] ? mq[i][0] : 8'h00;
        e_fl[i] = (TO != 0) && (mtmr[i] == TO);
      end
      chk("mon_valid", bus.packet_valid_o, e_pv);
      chk("mon_out", bus.packet_out, e_out);
      chk("mon_stop", bus.stop_packet_send, exp_stop());
      chk("mon_perr", bus.parity_err, m_err);
      chk("mon_drop", bus.pkt_dropped, m_dpulse);
      chk("mon_flush", bus.port_flushed, e_fl);
    end
  end

  // ---------------- collector ----------------
  bit [7:0] got [NP][$];
  int err_cnt, drop_cnt, stop_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++)
        if (bus.read_enb[i] && bus.packet_valid_o[i]) got[i].push_back(bus.packet_out[i*DW +: DW]);
      if (bus.parity_err) err_cnt++;
      if (bus.pkt_dropped) drop_cnt++;
      if (bus.packet_valid_i && bus.stop_packet_send) stop_cnt++;
    end
  end

  task automatic clear_col();
    for (int i = 0; i < NP; i++) got[i].delete();
    err_cnt = 0; drop_cnt = 0; stop_cnt = 0;
  endtask

  // ---------------- drivers (entered/left at posedge+1) ----------------
  task automatic idle(input int n);
    bus.packet_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_byte(input bit [7:0] b);
    int n;
    bit ok;
    n = 0; ok = 0;
    bus.packet_in = b;
    bus.packet_valid_i = 1'b1;
    while (n < 200 && !ok) begin
      @(negedge clk);
      ok = !bus.stop_packet_send;
      @(posedge clk); #1;
      n++;
    end
    bus.packet_valid_i = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL drive_timeout: byte %0h not accepted within 200 cycles", b);
    end
  endtask

  // ---------------- packet table ----------------
  typedef struct {
    bit [7:0] b [8];
    int       n;
    int       port;
    int       exp_err;
    int       exp_drop;
  } vec_t;

  vec_t vecs [7];

  // random read enable
  bit rnd_rd = 0;
  int rd_cyc = 0;
  int rd_phase [3] = '{0, 25, 100};
  always @(posedge clk) begin
    if (rnd_rd) begin
      #1;
      rd_cyc++;
      for (int i = 0; i < NP; i++)
        bus.read_enb[i] = ($urandom_range(0, 99) < rd_phase[(rd_cyc / 150) % 3]);
    end
  end

  bit [7:0] bp [7];
  int acc, k, n, ok_int;
  bit [7:0] q [$];
  bit [7:0] x;

  initial begin
    bus.packet_in = '0;
    bus.packet_valid_i = 1'b0;
    bus.read_enb = '0;
    clear_col();

    vecs[0] = '{b:'{8'h0D,8'h11,8'h22,8'h33,8'h0D,0,0,0}, n:5, port:1, exp_err:0, exp_drop:0};
    vecs[1] = '{b:'{8'h0D,8'h11,8'h22,8'h33,8'h0E,0,0,0}, n:5, port:1, exp_err:1, exp_drop:0};
    vecs[2] = '{b:'{8'h0B,8'hAA,8'hBB,8'h00,0,0,0,0},     n:4, port:-1, exp_err:0, exp_drop:1};
    vecs[3] = '{b:'{8'h00,8'h00,0,0,0,0,0,0},             n:2, port:0, exp_err:0, exp_drop:0};
    vecs[4] = '{b:'{8'h0A,8'h5A,8'hC3,8'h93,0,0,0,0},     n:4, port:2, exp_err:0, exp_drop:0};
    vecs[5] = '{b:'{8'h05,8'hFF,8'hFB,0,0,0,0,0},         n:3, port:1, exp_err:1, exp_drop:0};
    vecs[6] = '{b:'{8'h03,8'h77,0,0,0,0,0,0},             n:2, port:-1, exp_err:0, exp_drop:1};

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.packet_valid_o, 0);
    chk("rst_out", bus.packet_out, 0);
    chk("rst_stop", bus.stop_packet_send, 0);
    chk("rst_perr", bus.parity_err, 0);
    chk("rst_drop", bus.pkt_dropped, 0);
    chk("rst_flush", bus.port_flushed, 0);
    @(posedge clk); #1;

    // header latency: visible one edge after acceptance
    bus.packet_in = 8'h0D; bus.packet_valid_i = 1'b1;
    @(negedge clk);
    chk("lat_before", bus.packet_valid_o[1], 0);
    @(posedge clk); #1;
    bus.packet_valid_i = 1'b0;
    chk("lat_after", bus.packet_valid_o[1], 1);
    chk("lat_head", bus.packet_out[1*DW +: DW], 8'h0D);
    bus.read_enb = '1;
    drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33); drive_byte(8'h0D);
    idle(8);

    // parity error pulse timing
    drive_byte(8'h0D); drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33);
    drive_byte(8'h0E);
    chk("perr_pulse", bus.parity_err, 1);
    @(posedge clk); #1;
    chk("perr_width", bus.parity_err, 0);
    idle(8);

    // table of packets, consumer always reading
    for (int v = 0; v < 7; v++) begin
      clear_col();
      bus.read_enb = '1;
      for (int j = 0; j < vecs[v].n; j++) drive_byte(vecs[v].b[j]);
      idle(8);
      for (int p = 0; p < NP; p++) begin
        ok_int = 1;
        if (p == vecs[v].port) begin
          if (got[p].size() != vecs[v].n) ok_int = 0;
          else for (int j = 0; j < vecs[v].n; j++) if (got[p][j] != vecs[v].b[j]) ok_int = 0;
        end else if (got[p].size() != 0) ok_int = 0;
        if (!ok_int) begin
          n_cmp++; n_fail++;
          $display("FAIL vec%0d_port%0d_data: got %0d bytes, expected %0d", v, p,
                   got[p].size(), (p == vecs[v].port) ? vecs[v].n : 0);
        end else n_cmp++;
      end
      chk($sformatf("vec%0d_perr", v), err_cnt, vecs[v].exp_err);
      chk($sformatf("vec%0d_drop", v), drop_cnt, vecs[v].exp_drop);
      chk($sformatf("vec%0d_stop", v), stop_cnt, 0);
    end

    // backpressure: depth 4, header 0x14 = dest 0 len 5
    clear_col();
    bus.read_enb = '0;
    bp = '{8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h15};
    for (int j = 0; j < 4; j++) drive_byte(bp[j]);
    bus.packet_in = bp[4]; bus.packet_valid_i = 1'b1;
    @(negedge clk);
    chk("bp_stop_full", bus.stop_packet_send, 1);
    @(posedge clk); #1;
    bus.read_enb = 3'b001;
    @(negedge clk);
    chk("bp_stop_read_same_cycle", bus.stop_packet_send, 1);
    @(posedge clk); #1;
    bus.read_enb = '0;
    acc = 0; k = 4;
    repeat (5) begin
      @(negedge clk);
      ok_int = !bus.stop_packet_send;
      @(posedge clk); #1;
      if (ok_int) begin
        acc++;
        if (k < 6) k++;
        bus.packet_in = bp[k];
      end
    end
    chk("bp_one_more", acc, 1);
    bus.packet_valid_i = 1'b0;
    bus.read_enb = '1;
    for (int j = k; j < 7; j++) drive_byte(bp[j]);
    idle(12);
    ok_int = (got[0].size() == 7);
    if (ok_int) for (int j = 0; j < 7; j++) if (got[0][j] != bp[j]) ok_int = 0;
    chk("bp_order", ok_int, 1);
    chk("bp_perr", err_cnt, 0);

    // timeout: dest 2 len 1, never read
    bus.read_enb = '0;
    drive_byte(8'h06); drive_byte(8'h55); drive_byte(8'h53);
    n = 2;
    while (n < 100) begin
      @(negedge clk);
      if (bus.port_flushed[2]) break;
      @(posedge clk); #1;
      n++;
    end
    chk("to_cycles", n, 30);
    @(posedge clk); #1;
    chk("to_empty", bus.packet_valid_o[2], 0);
    // a single pop restarts the count
    drive_byte(8'h06); drive_byte(8'h55); drive_byte(8'h53);
    n = 2;
    while (n < 10) begin @(posedge clk); #1; n++; end
    bus.read_enb = 3'b100;
    @(posedge clk); #1;
    bus.read_enb = '0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.port_flushed[2]) break;
      @(posedge clk); #1;
      n++;
    end
    chk("to_restart_cycles", n, 30);
    @(posedge clk); #1;
    chk("to_restart_empty", bus.packet_valid_o[2], 0);

    // reset mid-packet
    drive_byte(8'h0D); drive_byte(8'h11); drive_byte(8'h22);
    bus.packet_in = 8'h33; bus.packet_valid_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.packet_valid_o, 0);
    chk("mid_rst_out", bus.packet_out, 0);
    chk("mid_rst_stop", bus.stop_packet_send, 0);
    chk("mid_rst_flush", bus.port_flushed, 0);
    bus.packet_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_col();
    bus.read_enb = '1;
    drive_byte(8'h04); drive_byte(8'h77); drive_byte(8'h73);
    idle(8);
    ok_int = (got[0].size() == 3) && (got[1].size() == 0);
    if (ok_int) ok_int = (got[0][0] == 8'h04) && (got[0][1] == 8'h77) && (got[0][2] == 8'h73);
    chk("post_rst_route", ok_int, 1);
    chk("post_rst_perr", err_cnt, 0);

    // randomized traffic, checked cycle by cycle by the monitor
    rnd_rd = 1;
    for (int p = 0; p < 150; p++) begin
      int d, len;
      d = $urandom_range(0, 3);
      len = $urandom_range(0, 6);
      q.delete();
      x = 8'((len << AW) | d);
      q.push_back(x);
      for (int j = 0; j < len; j++) begin
        q.push_back(8'($urandom_range(0, 255)));
        x ^= q[q.size() - 1];
      end
      if ($urandom_range(0, 4) == 0) x ^= 8'h01;
      q.push_back(x);
      foreach (q[j]) begin
        drive_byte(q[j]);
        idle($urandom_range(0, 2));
      end
    end
    rnd_rd = 0;
    @(posedge clk); #1;
    bus.read_enb = '1;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
